// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default frame geometry and the parity helper
// used by both the receive and transmit paths.
package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  // Parity bit that makes data+bit match the requested sense; data is zero-extended.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; reset value selectable.
module rx_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, sync_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framing: start detection, mid-bit sampling of data/parity/stop on an
// oversampled baud tick, and valid/ready presentation of the assembled word.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_baud_tick,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic                 armed_q, armed_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d;
  logic                 stop_q, stop_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_q, perro_q, ovr_q;

  rx_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_rx),
    .o_q       (rx_s)
  );

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    if (i_baud_tick) begin
      case (state_q)
        S_IDLE: begin
          // Requiring a high sample first keeps a held-low line from retriggering.
          armed_d = rx_s;
          if (armed_q && !rx_s) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_MID) begin
            if (rx_s) state_d = S_IDLE;
            else begin
              state_d = S_DATA;
              cnt_d   = '0;
              idx_d   = '0;
            end
          end else cnt_d = cnt_q + CW'(1);
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
            cnt_d = '0;
            idx_d = idx_q + IW'(1);
            if (idx_q == IDX_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else cnt_d = cnt_q + CW'(1);
        end
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            perr_d  = calc_parity(9'(sh_q), ODD) ^ rx_s;
            cnt_d   = '0;
            state_d = S_STOP;
          end else cnt_d = cnt_q + CW'(1);
        end
        S_STOP: begin
          // Leave half a bit early so the next start edge is not missed.
          if (cnt_q == CNT_LAST) begin
            stop_d  = rx_s;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else cnt_d = cnt_q + CW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= (state_d == S_IDLE) ? armed_d : 1'b0;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perro_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (done_q) begin
      data_q  <= sh_q;
      ferr_q  <= ~stop_q;
      perro_q <= perr_q;
      valid_q <= 1'b1;
      ovr_q   <= valid_q & ~i_ready;
    end else begin
      ovr_q <= 1'b0;
      if (valid_q && i_ready) valid_q <= 1'b0;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perro_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed plus randomized bench for the UART receive framer (8N1 and 8E1 instances).
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

  localparam int OS = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  logic       clk, rst_n, tick, rx, rx_p, ready;
  logic [7:0] o_data, p_data;
  logic       o_valid, o_ferr, o_perr, o_ovr, o_busy;
  logic       p_valid, p_ferr, p_perr, p_ovr, p_busy;

  int   total = 0;
  int   bad   = 0;
  int   ovr_cnt = 0;
  rec_t q0[$];
  rec_t q1[$];

  uart_rx_frame_ctrl #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_baud_tick(tick), .i_rx(rx), .i_ready(ready),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_ferr), .o_parity_err(o_perr),
    .o_overrun(o_ovr), .o_busy(o_busy));

  uart_rx_frame_ctrl #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .i_clk(clk), .i_reset_n(rst_n), .i_baud_tick(tick), .i_rx(rx_p), .i_ready(ready),
    .o_data(p_data), .o_valid(p_valid), .o_frame_err(p_ferr), .o_parity_err(p_perr),
    .o_overrun(p_ovr), .o_busy(p_busy));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick = 0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1;
      @(negedge clk);
      tick = 0;
    end
  end

  // Record every accepted word and every overrun pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && ready) q0.push_back({o_data, o_ferr, o_perr});
      if (p_valid && ready) q1.push_back({p_data, p_ferr, p_perr});
      if (o_ovr) ovr_cnt <= ovr_cnt + 1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    #1;
  endtask

  task automatic drive(input bit sel, input bit b);
    if (sel) rx_p = b;
    else     rx   = b;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit pen,
                            input bit pb, input bit stopb);
    drive(sel, 1'b0);
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      wait_ticks(OS);
    end
    if (pen) begin
      drive(sel, pb);
      wait_ticks(OS);
    end
    drive(sel, stopb);
    wait_ticks(OS);
  endtask

  task automatic idle(input bit sel, input bit lvl, input int n);
    drive(sel, lvl);
    wait_ticks(n);
  endtask

  // Reference: expected record for a frame, from the line-level frame contents.
  function automatic rec_t model(input logic [7:0] d, input bit pen, input bit pb,
                                 input bit odd, input bit stopb);
    rec_t r;
    int   ones;
    r.d  = d;
    r.fe = !stopb;
    ones = $countones(d) + int'(pb);
    r.pe = pen ? (odd ? (ones % 2 == 0) : (ones % 2 == 1)) : 1'b0;
    return r;
  endfunction

  task automatic expect_rec(input bit sel, input string tag, input rec_t e);
    rec_t r;
    int   n;
    n = sel ? q1.size() : q0.size();
    chk({tag, "_count"}, n, 1);
    if (n > 0) begin
      r = sel ? q1.pop_front() : q0.pop_front();
      chk({tag, "_data"}, r.d, e.d);
      chk({tag, "_ferr"}, r.fe, e.fe);
      chk({tag, "_perr"}, r.pe, e.pe);
    end
  endtask

  initial begin
    logic [7:0] d;
    bit         sb, pb;
    rst_n = 0; rx = 1; rx_p = 1; ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_flags", {o_ferr, o_perr, o_ovr, o_busy}, 0);
    rst_n = 1;
    idle(0, 1, 32);

    // Basic 8N1 frame
    send_frame(0, 8'hA5, 0, 0, 1);
    idle(0, 1, 32);
    expect_rec(0, "a5", model(8'hA5, 0, 0, 0, 1));
    chk("a5_busy", o_busy, 0);

    // Short glitch must be rejected as a false start
    idle(0, 0, 4);
    idle(0, 1, 40);
    chk("glitch_q", q0.size(), 0);
    chk("glitch_busy", o_busy, 0);
    send_frame(0, 8'h3C, 0, 0, 1);
    idle(0, 1, 32);
    expect_rec(0, "3c", model(8'h3C, 0, 0, 0, 1));

    // Framing error then a held-low line
    send_frame(0, 8'h55, 0, 0, 0);
    idle(0, 0, 3 * OS);
    expect_rec(0, "ferr", model(8'h55, 0, 0, 0, 0));
    chk("break_q", q0.size(), 0);
    idle(0, 1, 2 * OS);
    send_frame(0, 8'h01, 0, 0, 1);
    idle(0, 1, 32);
    expect_rec(0, "01", model(8'h01, 0, 0, 0, 1));

    // Overrun with consumer stalled
    ready = 0;
    send_frame(0, 8'h11, 0, 0, 1);
    idle(0, 1, 32);
    chk("ovr1_valid", o_valid, 1);
    chk("ovr1_data", o_data, 8'h11);
    chk("ovr1_cnt", ovr_cnt, 0);
    send_frame(0, 8'h22, 0, 0, 1);
    idle(0, 1, 32);
    chk("ovr2_cnt", ovr_cnt, 1);
    chk("ovr2_valid", o_valid, 1);
    chk("ovr2_data", o_data, 8'h22);
    ready = 1;
    @(posedge clk); #1;
    chk("ovr_drop", o_valid, 0);
    expect_rec(0, "ovr", model(8'h22, 0, 0, 0, 1));

    // Even parity instance
    idle(1, 1, 32);
    send_frame(1, 8'h07, 1, 0, 1);
    idle(1, 1, 32);
    expect_rec(1, "par_bad", model(8'h07, 1, 0, 0, 1));
    send_frame(1, 8'h07, 1, 1, 1);
    idle(1, 1, 32);
    expect_rec(1, "par_ok", model(8'h07, 1, 1, 0, 1));

    // Reset during data bit 4 discards the partial word
    drive(0, 0);
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      drive(0, i[0]);
      wait_ticks(OS);
    end
    drive(0, 1'b0);
    wait_ticks(OS / 2);
    rst_n = 0;
    #1;
    chk("mrst_valid", o_valid, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_flags", {o_data, o_ferr, o_perr, o_ovr}, 0);
    rx = 1;
    repeat (4) @(negedge clk);
    rst_n = 1;
    idle(0, 1, 48);
    chk("mrst_q", q0.size(), 0);
    send_frame(0, 8'hC3, 0, 0, 1);
    idle(0, 1, 32);
    expect_rec(0, "c3", model(8'hC3, 0, 0, 0, 1));

    // Randomized frames on both instances
    for (int n = 0; n < 8; n++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(0, d, 0, 0, sb);
      idle(0, 1, 2 * OS);
      expect_rec(0, "rnd", model(d, 0, 0, 0, sb));
      d  = 8'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(1, d, 1, pb, sb);
      idle(1, 1, 2 * OS);
      expect_rec(1, "rndp", model(d, 1, pb, 0, sb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
